// File: rtl/ifetch_stage.sv
// Purpose : instruction-fetch stage; turns PC-stage addresses into instruction-bus
//           requests and queues returned instructions in order for decode.
// Latency : address accepted -> bus request next cycle; data_ok -> if_valid_o next cycle.
// Backpressure: a PC is taken only when buffer entries plus the in-flight fetch leave
//           room, so a returning instruction always has a slot; decode stalls via id_ready_i.
//
// Ports:
//   clk, resetn                    clock, synchronous active-low reset
//   pc_i/pc_valid_i/pc_ready_o     fetch-address handshake from the PC stage
//   flush_i                        redirect: kill buffered entries and the in-flight fetch
//   inst_req/inst_addr/inst_addr_ok/inst_rdata/inst_data_ok   SRAM-like instruction bus
//   if_valid_o/if_pc_o/if_inst_o/if_adel_o/id_ready_i         buffer head towards decode
module ifetch_stage #(
    parameter int          BUF_DEPTH  = 2,
    parameter logic [31:0] RESET_INST = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pc_i,
    input  logic        pc_valid_i,
    output logic        pc_ready_o,
    input  logic        flush_i,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic [31:0] inst_rdata,
    input  logic        inst_data_ok,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_adel_o,
    input  logic        id_ready_i
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    // REQ_C: request still on the bus but already flushed; its data must be dropped.
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_REQ_C,
        S_WAIT,
        S_CANCEL
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [31:0]    r_addr;
    logic [31:0]    r_pc_mem   [BUF_DEPTH];
    logic [31:0]    r_inst_mem [BUF_DEPTH];
    logic           r_adel_mem [BUF_DEPTH];
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;

    logic           w_inflight;
    logic [CW:0]    w_occ;
    logic           w_space;
    logic           w_aligned;
    logic           w_accept;
    logic           w_latch;
    logic           w_push;
    logic [31:0]    w_push_pc;
    logic [31:0]    w_push_inst;
    logic           w_push_adel;
    logic           w_head_vld;
    logic           w_pop;

    // Reserve a slot for the fetch on the bus; same-cycle pops are deliberately ignored
    // so that pc_ready_o does not depend combinationally on id_ready_i.
    assign w_inflight = (r_state == S_REQ) || (r_state == S_WAIT);
    assign w_occ      = {1'b0, r_count} + {{CW{1'b0}}, w_inflight};
    assign w_space    = w_occ < (CW+1)'(BUF_DEPTH);
    assign w_aligned  = (pc_i[1:0] == 2'b00);

    // Besides IDLE, an aligned PC may be taken in the data_ok cycle of WAIT so the next
    // request goes out immediately (back-to-back fetch).
    assign pc_ready_o = !flush_i && resetn && w_space &&
                        ((r_state == S_IDLE) ||
                         ((r_state == S_WAIT) && inst_data_ok && w_aligned));
    assign w_accept   = pc_valid_i && pc_ready_o;

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_push      = 1'b0;
        w_push_pc   = r_addr;
        w_push_inst = inst_rdata;
        w_push_adel = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_aligned) begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_REQ;
                    end else begin
                        // Misaligned: no bus access, exception entry queued in order.
                        w_push      = 1'b1;
                        w_push_pc   = pc_i;
                        w_push_inst = RESET_INST;
                        w_push_adel = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (flush_i) begin
                    w_state_nxt = inst_addr_ok ? S_CANCEL : S_REQ_C;
                end else if (inst_addr_ok) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_REQ_C: begin
                if (inst_addr_ok) begin
                    w_state_nxt = S_CANCEL;
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    w_state_nxt = inst_data_ok ? S_IDLE : S_CANCEL;
                end else if (inst_data_ok) begin
                    w_push = 1'b1;
                    if (w_accept) begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_CANCEL: begin
                if (inst_data_ok) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign inst_req   = (r_state == S_REQ) || (r_state == S_REQ_C);
    assign inst_addr  = r_addr;

    assign w_head_vld = (r_count != '0);
    // A pop in the flush cycle is void: the whole buffer is discarded anyway.
    assign w_pop      = w_head_vld && id_ready_i && !flush_i;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_addr   <= 32'h0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_addr <= pc_i;
            end
            if (flush_i) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // Storage needs no reset: entries are only visible while r_count covers them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= w_push_pc;
            r_inst_mem[r_wr_ptr] <= w_push_inst;
            r_adel_mem[r_wr_ptr] <= w_push_adel;
        end
    end

    assign if_valid_o = w_head_vld;
    assign if_pc_o    = w_head_vld ? r_pc_mem[r_rd_ptr]   : 32'h0;
    assign if_inst_o  = w_head_vld ? r_inst_mem[r_rd_ptr] : RESET_INST;
    assign if_adel_o  = w_head_vld ? r_adel_mem[r_rd_ptr] : 1'b0;

endmodule

// File: tb/tb_ifetch_stage.sv
// Purpose : self-checking bench for ifetch_stage with a bus responder and an in-order scoreboard.
// Latency : responder addr_ok/data_ok delays are set per scenario.
// Backpressure: decode readiness driven per scenario; flushes empty the scoreboard.
module tb_ifetch_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic [31:0] inst_rdata = 32'h0;
    logic        inst_data_ok = 1'b0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_adel_o;
    logic        id_ready_i;

    ifetch_stage #(.BUF_DEPTH(2), .RESET_INST(32'h0)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .pc_i         (pc_i),
        .pc_valid_i   (pc_valid_i),
        .pc_ready_o   (pc_ready_o),
        .flush_i      (flush_i),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_rdata   (inst_rdata),
        .inst_data_ok (inst_data_ok),
        .if_valid_o   (if_valid_o),
        .if_pc_o      (if_pc_o),
        .if_inst_o    (if_inst_o),
        .if_adel_o    (if_adel_o),
        .id_ready_i   (id_ready_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'hbfc00000: return 32'h24080001;
            32'hbfc00010: return 32'hdeadbeef;
            default:      return a ^ 32'h3c1d_0000;
        endcase
    endfunction

    // ---------------- bus responder (drives on negedge) ----------------
    int          addr_delay = 0;
    int          data_lat   = 1;
    bit          bus_busy   = 0;
    int          bus_wait   = 0;
    int          bus_lat    = 0;
    logic [31:0] bus_addr   = 32'h0;
    int          hs_cnt     = 0;
    logic [31:0] last_hs_addr = 32'h0;
    int          dok_cyc    = 0;

    always @(negedge clk) begin
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        if (!resetn) begin
            bus_busy = 0;
            bus_wait = 0;
        end else if (bus_busy) begin
            if (bus_lat == 0) begin
                inst_data_ok = 1'b1;
                inst_rdata   = memf(bus_addr);
                bus_busy     = 0;
                dok_cyc      = cyc;
            end else begin
                bus_lat--;
            end
        end else if (inst_req) begin
            if (bus_wait >= addr_delay) begin
                inst_addr_ok = 1'b1;
                bus_addr     = inst_addr;
                last_hs_addr = inst_addr;
                bus_busy     = 1;
                bus_lat      = data_lat - 1;
                bus_wait     = 0;
                hs_cnt++;
            end else begin
                bus_wait++;
            end
        end
    end

    // ---------------- scoreboard / monitor (samples 1ns before posedge) ----------------
    logic [64:0] exp_q[$];
    logic [64:0] e;
    bit          stream_mode = 0;
    bit          have_prev   = 0;
    int          last_pop_cyc = 0;
    logic [31:0] last_pop_pc  = 32'h0;
    int          n_pops = 0;
    bit          saw_dead = 0;
    logic        p_req = 1'b0;
    logic        p_aok = 1'b0;
    logic [31:0] p_addr = 32'h0;

    always @(negedge clk) begin
        #4;
        if (resetn) begin
            if (p_req && !p_aok) begin
                chk("req_hold", {31'h0, inst_req}, 32'h1);
                chk("addr_hold", inst_addr, p_addr);
            end
            if (if_valid_o && if_inst_o == 32'hdeadbeef) saw_dead = 1;
            if (stream_mode && inst_data_ok) chk("stream_rdy", {31'h0, pc_ready_o}, 32'h1);
            if (flush_i) begin
                exp_q.delete();
            end else begin
                if (if_valid_o && id_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_unexpected", if_pc_o, 32'hffff_ffff);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_pc",   if_pc_o,   e[64:33]);
                        chk("sb_inst", if_inst_o, e[32:1]);
                        chk("sb_adel", {31'h0, if_adel_o}, {31'h0, e[0]});
                    end
                    if (stream_mode && have_prev) chk("stream_gap", 32'(cyc - last_pop_cyc), 32'd2);
                    have_prev    = 1;
                    last_pop_cyc = cyc;
                    last_pop_pc  = if_pc_o;
                    n_pops++;
                end
                if (pc_valid_i && pc_ready_o) begin
                    if (pc_i[1:0] != 2'b00) exp_q.push_back({pc_i, 32'h0, 1'b1});
                    else                    exp_q.push_back({pc_i, memf(pc_i), 1'b0});
                end
            end
        end
        p_req  = inst_req;
        p_aok  = inst_addr_ok;
        p_addr = inst_addr;
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic send_pc(input logic [31:0] pc);
        int n = 0;
        pc_i       = pc;
        pc_valid_i = 1'b1;
        #4;
        while (!pc_ready_o && n < 100) begin
            @(negedge clk);
            #4;
            n++;
        end
        if (!pc_ready_o) chk("accept_timeout", 32'h0, 32'h1);
        @(negedge clk);
        pc_valid_i = 1'b0;
    endtask

    task automatic wait_vld(input string tag);
        int n = 0;
        while (!if_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!if_valid_o) chk({tag, "_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while ((if_valid_o || exp_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (if_valid_o || exp_q.size() != 0) chk({tag, "_drain_timeout"}, 32'h0, 32'h1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    int  hs0;
    int  p0;
    bit  seen_aok;
    bit  seen_dok;

    initial begin
        resetn     = 1'b0;
        pc_valid_i = 1'b1;
        pc_i       = 32'hbfc00000;
        flush_i    = 1'b0;
        id_ready_i = 1'b0;

        // reset: pc_ready_o must stay low even with a valid PC offered
        repeat (3) begin
            @(negedge clk);
            #4;
            chk("rst_pc_ready", {31'h0, pc_ready_o}, 32'h0);
        end
        chk("rst_req",   {31'h0, inst_req},   32'h0);
        chk("rst_addr",  inst_addr,           32'h0);
        chk("rst_vld",   {31'h0, if_valid_o}, 32'h0);
        chk("rst_pc",    if_pc_o,             32'h0);
        chk("rst_inst",  if_inst_o,           32'h0);
        chk("rst_adel",  {31'h0, if_adel_o},  32'h0);
        @(negedge clk);
        resetn     = 1'b1;
        pc_valid_i = 1'b0;
        @(negedge clk);

        // basic fetch
        addr_delay = 1; data_lat = 2;
        hs0 = hs_cnt;
        send_pc(32'hbfc00000);
        wait_vld("basic");
        chk("basic_vld_lat", 32'(cyc - dok_cyc), 32'd1);
        chk("basic_pc",   if_pc_o,   32'hbfc00000);
        chk("basic_inst", if_inst_o, 32'h24080001);
        chk("basic_adel", {31'h0, if_adel_o}, 32'h0);
        chk("basic_hs",   32'(hs_cnt - hs0), 32'd1);
        chk("basic_addr", last_hs_addr, 32'hbfc00000);
        id_ready_i = 1'b1;
        wait_empty("basic");

        // streaming
        addr_delay = 0; data_lat = 1;
        p0 = n_pops;
        have_prev = 0;
        stream_mode = 1;
        for (int i = 0; i < 4; i++) send_pc(32'hbfc00000 + 32'(4 * i));
        wait_empty("stream");
        stream_mode = 0;
        chk("stream_cnt", 32'(n_pops - p0), 32'd4);

        // back-pressure
        id_ready_i = 1'b0;
        p0 = n_pops;
        send_pc(32'hbfc00100);
        send_pc(32'hbfc00104);
        repeat (4) @(negedge clk);
        pc_i = 32'hbfc00108;
        pc_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #4;
            chk("bp_pc_ready", {31'h0, pc_ready_o}, 32'h0);
            chk("bp_req",      {31'h0, inst_req},   32'h0);
            @(negedge clk);
        end
        chk("bp_head", if_pc_o, 32'hbfc00100);
        id_ready_i = 1'b1;
        send_pc(32'hbfc00108);
        wait_empty("bp");
        chk("bp_cnt", 32'(n_pops - p0), 32'd3);

        // flush in WAIT
        addr_delay = 0; data_lat = 4;
        send_pc(32'hbfc00010);
        @(negedge clk);
        flush_i    = 1'b1;
        pc_i       = 32'hbfc00380;
        pc_valid_i = 1'b1;
        #4;
        chk("fw_flush_ready", {31'h0, pc_ready_o}, 32'h0);
        @(negedge clk);
        flush_i = 1'b0;
        send_pc(32'hbfc00380);
        wait_empty("fw");
        chk("fw_last_pc", last_pop_pc, 32'hbfc00380);
        chk("fw_no_dead", {31'h0, saw_dead}, 32'h0);

        // flush in REQ before addr_ok
        addr_delay = 3; data_lat = 1;
        hs0 = hs_cnt;
        send_pc(32'hbfc00020);
        flush_i    = 1'b1;
        pc_i       = 32'hbfc00400;
        pc_valid_i = 1'b1;
        #4;
        chk("rc_flush_ready", {31'h0, pc_ready_o}, 32'h0);
        chk("rc_flush_req",   {31'h0, inst_req},   32'h1);
        @(negedge clk);
        flush_i  = 1'b0;
        seen_aok = 0;
        seen_dok = 0;
        for (int i = 0; i < 20 && !seen_dok; i++) begin
            #4;
            chk("rc_pc_ready", {31'h0, pc_ready_o}, 32'h0);
            if (!seen_aok) chk("rc_req", {31'h0, inst_req}, 32'h1);
            if (inst_addr_ok) seen_aok = 1;
            if (inst_data_ok) seen_dok = 1;
            @(negedge clk);
        end
        if (!seen_dok) chk("rc_dok_timeout", 32'h0, 32'h1);
        chk("rc_addr", last_hs_addr, 32'hbfc00020);
        send_pc(32'hbfc00400);
        wait_empty("rc");
        chk("rc_last_pc", last_pop_pc, 32'hbfc00400);
        chk("rc_hs", 32'(hs_cnt - hs0), 32'd2);

        // misaligned fetch
        addr_delay = 0; data_lat = 1;
        id_ready_i = 1'b0;
        hs0 = hs_cnt;
        send_pc(32'hbfc00002);
        chk("mis_vld",  {31'h0, if_valid_o}, 32'h1);
        chk("mis_adel", {31'h0, if_adel_o},  32'h1);
        chk("mis_inst", if_inst_o,           32'h0);
        chk("mis_pc",   if_pc_o,             32'hbfc00002);
        chk("mis_req",  {31'h0, inst_req},   32'h0);
        chk("mis_hs",   32'(hs_cnt - hs0),   32'd0);
        id_ready_i = 1'b1;
        wait_empty("mis");
        // AdEL entry queued behind a normal one
        id_ready_i = 1'b0;
        send_pc(32'hbfc00040);
        send_pc(32'hbfc00045);
        @(negedge clk);
        chk("mis_order_head", if_pc_o, 32'hbfc00040);
        id_ready_i = 1'b1;
        wait_empty("mis2");

        chk("sb_left", 32'(exp_q.size()), 32'd0);
        chk("total_pops", 32'(n_pops), 32'd13);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
Instruction-fetch stage directly downstream of the PC register. It accepts fetch addresses from the PC stage and issues them on the SRAM-like instruction bus (req / addr_ok / data_ok). Returned instructions are queued in a small in-order buffer that feeds the IF/ID boundary. It handles decode back-pressure, flushes for branch and exception redirects (including cancelling in-flight bus transactions), and reports misaligned-fetch (AdEL) exceptions.

Parameters:
BUF_DEPTH, 2, instruction buffer entries; power of two, >= 2
RESET_INST, 32'h0, instruction field value for AdEL entries and for empty-buffer output

Ports:
clk  in  1  clock; all state updates on posedge
resetn  in  1  synchronous reset, active-low
pc_i  in  32  fetch address from PC stage
pc_valid_i  in  1  pc_i is valid
pc_ready_o  out  1  pc_i accepted this cycle; the PC stage advances only when pc_valid_i && pc_ready_o
flush_i  in  1  redirect (branch or exception); kill buffer and in-flight fetch
inst_req  out  1  instruction bus request
inst_addr  out  32  request address, held stable while inst_req=1
inst_addr_ok  in  1  request accepted by bus
inst_rdata  in  32  returned instruction
inst_data_ok  in  1  inst_rdata valid
if_valid_o  out  1  buffer head valid
if_pc_o  out  32  PC of head entry
if_inst_o  out  32  instruction of head entry
if_adel_o  out  1  head entry raised a misaligned-fetch exception
id_ready_i  in  1  decode consumes the head entry

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE; buffer empty; inst_req=0; inst_addr=0; if_valid_o=0; if_pc_o=0; if_inst_o=RESET_INST; if_adel_o=0. pc_ready_o=0 while resetn=0.
- Buffer: circular FIFO of {pc, inst, adel}, count range 0..BUF_DEPTH. Head entry drives the if_* outputs. A pop occurs when if_valid_o && id_ready_i. Push and pop in the same cycle are allowed.
- Space reservation: an address is accepted only if count + inflight < BUF_DEPTH, where inflight=1 in REQ or WAIT, else 0. A push therefore never overflows. Pops in the current cycle are not counted when computing space.
- FSM states:
  - IDLE: inst_req=0.
  - REQ: inst_req=1, inst_addr=latched pc.
  - WAIT: waiting for inst_data_ok.
  - CANCEL: waiting for inst_data_ok, whose data is discarded.
- pc_ready_o = !flush_i && resetn && space && (state==IDLE || (state==WAIT && inst_data_ok && pc_i[1:0]==0)).
- IDLE, on accept:
  - pc_i[1:0]==0: latch the address, go to REQ.
  - Otherwise: push {pc_i, RESET_INST, adel=1} and stay in IDLE. No bus request is made.
- REQ: inst_req=1 and inst_addr are held until inst_addr_ok (req is never withdrawn before addr_ok). On inst_addr_ok, go to WAIT. Address-to-data latency is at least 1 cycle; data_ok is never sampled in REQ.
- WAIT, on inst_data_ok: push {addr, inst_rdata, 0}.
  - If a new pc is accepted the same cycle, go to REQ. This gives back-to-back fetch and 1 instruction per 2 cycles when addr_ok is immediate.
  - Otherwise go to IDLE.
- Flush (flush_i=1) has the highest priority:
  - Buffer is emptied next cycle (count=0, if_valid_o=0); any pop that cycle is void.
  - No pc is accepted in the flush cycle. The redirected pc is accepted from the following cycle.
  - IDLE: stay in IDLE.
  - REQ without addr_ok: go to a pending-cancel substate (REQ_C). inst_req stays 1 until addr_ok, then go to CANCEL.
  - REQ with addr_ok the same cycle: go to CANCEL.
  - WAIT without data_ok: go to CANCEL.
  - WAIT with data_ok the same cycle: discard the data, go to IDLE.
  - CANCEL or REQ_C: remain in that state.
- CANCEL: on inst_data_ok, drop inst_rdata and go to IDLE. pc_ready_o=0 in CANCEL and REQ_C.
- Misaligned fetch: the AdEL entry is ordered behind any earlier entries. It is delivered like a normal entry.
- Reset mid-transaction: a synchronous reset returns to IDLE. The bus side is reset in the same cycle, so no cancel is needed.

Test Plan:
- Basic fetch: reset low 3 cycles, then pc_i=0xbfc00000 valid, addr_ok 1 cycle after req, data_ok 2 cycles later with 0x24080001 -> exactly one inst_req handshake with inst_addr=0xbfc00000; if_valid_o=1, if_pc_o=0xbfc00000, if_inst_o=0x24080001, if_adel_o=0 the cycle after data_ok.
- Streaming: pc 0xbfc00000, +4, +8, +12; addr_ok immediate; data_ok 1 cycle after; id_ready_i=1 -> four entries out in order, one every 2 cycles, pc_ready_o high on each data_ok cycle.
- Back-pressure: id_ready_i=0, BUF_DEPTH=2 -> after 2 entries pc_ready_o=0 and inst_req stays 0. Raising id_ready_i drains the entries in order, then fetch resumes.
- Flush in WAIT: req 0xbfc00010 accepted, flush_i pulse, data_ok later with 0xdeadbeef, then pc 0xbfc00380 -> 0xdeadbeef never appears on if_inst_o; next delivered entry is pc=0xbfc00380.
- Flush in REQ before addr_ok: addr_ok withheld 3 cycles, flush at cycle 1 -> inst_req stays 1 with a stable address until addr_ok; its data is dropped; no pc is accepted until data_ok.
- Misaligned: pc_i=0xbfc00002 from IDLE -> no inst_req; next cycle if_valid_o=1, if_adel_o=1, if_inst_o=0, if_pc_o=0xbfc00002.
